// File: rtl/ram_read_scheduler_pkg.sv
// rtl/ram_read_scheduler_pkg.sv - shared constants and types for the capture-RAM read scheduler
package ram_read_scheduler_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 25;
  localparam int DEPTH  = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef enum logic {
    TAG_HOST  = 1'b0,
    TAG_DRAIN = 1'b1
  } rd_tag_e;
endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - 2-entry valid/ready buffer with occupancy count
module stream_skid_fifo
  import ram_read_scheduler_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid_i,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic         rd_q;
  logic         wr_q;
  logic [1:0]   count_q;
  logic         push;
  logic         pop;

  assign pop       = m_valid_o && m_ready_i;
  assign push      = s_valid_i && ((count_q != 2'd2) || pop);
  assign m_valid_o = (count_q != 2'd0);
  assign m_data_o  = mem_q[rd_q];
  assign count_o   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= s_data_i;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/ram_read_scheduler.sv
// rtl/ram_read_scheduler.sv - shares the capture-RAM read port between host reads and a frame drain stream
module ram_read_scheduler
  import ram_read_scheduler_pkg::*;
#(
  parameter int ADDR_W = ram_read_scheduler_pkg::ADDR_W,
  parameter int DATA_W = ram_read_scheduler_pkg::DATA_W,
  parameter int DEPTH  = ram_read_scheduler_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_active,
  input  logic              frame_done,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_add,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_read_add,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic              busy,
  output logic              overrun_err
);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic              pending_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued_q;  // doubles as the drain read pointer
  logic [ADDR_W:0]   sent_q, sent_d;
  rd_tag_e           rr_q;
  logic              rd_vld_q;
  rd_tag_e           rd_tag_q;
  logic              host_ack_q;
  logic [DATA_W-1:0] host_data_q;
  logic              overrun_q;

  logic [1:0] buf_count;
  logic [2:0] occupancy;
  logic       drain_inflight, host_inflight, pop;
  logic       drain_elig, host_elig, grant_host, grant_drain;
  logic       fd_accept, start_drain;

  assign drain_inflight = rd_vld_q && (rd_tag_q == TAG_DRAIN);
  assign host_inflight  = rd_vld_q && (rd_tag_q == TAG_HOST);
  assign pop            = m_valid && m_ready;
  assign sent_d         = sent_q + (ADDR_W+1)'(pop);
  // A word leaving the buffer this cycle frees its slot, keeping 1 word/cycle at full rate
  assign occupancy      = 3'(buf_count) + 3'(drain_inflight) - 3'(pop);
  assign fd_accept      = frame_done && (state_q == IDLE) && !pending_q &&
                          (frame_len != '0) && (frame_len <= LEN_MAX);
  assign start_drain    = (state_q == IDLE) && (state_d == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending_q && !wr_active) state_d = DRAIN;
      DRAIN:   if (issued_q == len_q)       state_d = FLUSH;
      FLUSH:   if (sent_d == len_q)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drain_elig  = (state_q == DRAIN) && (issued_q < len_q) && (occupancy < 3'd2);
    host_elig   = rst_n && host_req && !host_inflight && !host_ack_q;
    grant_host  = 1'b0;
    grant_drain = 1'b0;
    if (host_elig && drain_elig) begin
      if (rr_q == TAG_DRAIN) grant_host  = 1'b1;
      else                   grant_drain = 1'b1;
    end else begin
      grant_host  = host_elig;
      grant_drain = drain_elig;
    end
    ram_rd_en    = grant_host || grant_drain;
    ram_read_add = grant_host  ? host_add :
                   grant_drain ? issued_q[ADDR_W-1:0] : '0;
    busy         = pending_q || (state_q != IDLE);
    m_last       = m_valid && (sent_q == len_q - ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= 1'b0;
      len_q       <= '0;
      issued_q    <= '0;
      sent_q      <= '0;
      rr_q        <= TAG_HOST;
      rd_vld_q    <= 1'b0;
      rd_tag_q    <= TAG_HOST;
      host_ack_q  <= 1'b0;
      host_data_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (start_drain)    pending_q <= 1'b0;
      else if (fd_accept) pending_q <= 1'b1;
      if (fd_accept)                len_q     <= frame_len;
      if (frame_done && !fd_accept) overrun_q <= 1'b1;
      if (start_drain) begin
        issued_q <= '0;
        sent_q   <= '0;
      end else begin
        if (grant_drain) issued_q <= issued_q + ONE;
        sent_q <= sent_d;
      end
      if (host_elig && drain_elig) rr_q <= grant_host ? TAG_HOST : TAG_DRAIN;
      rd_vld_q   <= ram_rd_en;
      rd_tag_q   <= grant_drain ? TAG_DRAIN : TAG_HOST;
      host_ack_q <= host_inflight;
      if (host_inflight) host_data_q <= ram_read_data;
    end
  end

  assign host_ack    = host_ack_q;
  assign host_data   = host_data_q;
  assign overrun_err = overrun_q;

  stream_skid_fifo #(.W(DATA_W)) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid_i (drain_inflight),
    .s_data_i  (ram_read_data),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .count_o   (buf_count)
  );
endmodule
